// File: rtl/config_pkg.sv
// Shared number format, vector shape and operation encoding for the rowwise operation unit.
// Signed Q8.8 elements; every ALU result saturates to the 16-bit signed range.
package config_pkg;

  localparam int VectorLength = 8;
  localparam int FracBits     = 8;
  localparam int IdxWidth     = $clog2(VectorLength);

  typedef logic signed [15:0] element_t;
  typedef element_t [VectorLength-1:0] vector_t;

  typedef enum logic [2:0] {ADD, SUB, MUL, DIV, EXP} operation_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic element_t sat16(input logic signed [31:0] x);
    if (x > 32'sd32767)       return 16'sh7FFF;
    else if (x < -32'sd32768) return 16'sh8000;
    else                      return x[15:0];
  endfunction

endpackage

// File: rtl/rowwise_element_alu.sv
// Combinational single-element ALU: ADD/SUB/MUL/DIV/EXP on Q8.8 operands, saturated output.
// EXP uses 2^(x*log2 e) with a linear mantissa, so it is an approximation of e^x.
module rowwise_element_alu
  import config_pkg::*;
(
  input  operation_t op_i,
  input  element_t   a_i,
  input  element_t   b_i,
  output element_t   result_o
);

  logic signed [31:0] a_ext;
  logic signed [31:0] b_ext;
  logic signed [31:0] prod;
  logic signed [31:0] y;
  logic signed [31:0] k;
  logic        [15:0] mant;

  // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latches).
  always_comb begin
    a_ext    = {{16{a_i[15]}}, a_i};
    b_ext    = {{16{b_i[15]}}, b_i};
    prod     = '0;
    y        = '0;
    k        = '0;
    mant     = '0;
    result_o = '0;
    case (op_i)
      ADD: result_o = sat16(a_ext + b_ext);
      SUB: result_o = sat16(a_ext - b_ext);
      MUL: begin
        prod     = a_ext * b_ext;
        result_o = sat16(prod >>> FracBits);
      end
      DIV: begin
        if (b_i == '0) result_o = a_i[15] ? 16'sh8000 : 16'sh7FFF;
        else           result_o = sat16((a_ext <<< FracBits) / b_ext);
      end
      EXP: begin
        // 369 = log2(e) in Q8.8; k is the integer exponent, y[7:0] the fraction.
        y    = (a_ext * 32'sd369) >>> FracBits;
        k    = y >>> FracBits;
        mant = 16'd256 + {8'd0, y[7:0]};
        if (k >= 32'sd7)       result_o = 16'sh7FFF;
        else if (k < -32'sd9)  result_o = '0;
        else if (k >= 32'sd0)  result_o = mant << k;
        else                   result_o = mant >> (-k);
      end
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/rowwise_operation_unit.sv
// Valid/ready stage applying one elaboration-selected operation element-by-element to two
// vectors through a shared ALU, one element per cycle: IDLE -> BUSY (8 cycles) -> DONE.
module rowwise_operation_unit
  import config_pkg::*;
#(
  parameter operation_t operation = ADD
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  vector_t a_i,
  input  vector_t b_i,
  input  logic    in_valid_i,
  output logic    in_ready_o,
  output logic    out_valid_o,
  input  logic    out_ready_i,
  output vector_t vector_o
);

  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(VectorLength - 1);

  state_t              state_q, state_d;
  logic [IdxWidth-1:0] idx_q, idx_d;
  vector_t             a_q, a_d;
  vector_t             b_q, b_d;
  vector_t             result_q, result_d;
  element_t            alu_result;
  logic                accept;

  rowwise_element_alu u_alu (
    .op_i     (operation),
    .a_i      (a_q[idx_q]),
    .b_i      (b_q[idx_q]),
    .result_o (alu_result)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  // NOTE: operand registers are pure data, always loaded before use, so they carry no reset.
  always_ff @(posedge clk_i) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)             state_d = BUSY;
      BUSY:    if (idx_q == LastIdx)   state_d = DONE;
      DONE:    if (out_ready_i)        state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == IDLE) && !rst_i;
    out_valid_o = (state_q == DONE);
  end

  assign accept = in_valid_i && in_ready_o;

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    result_d = result_q;
    if (accept) begin
      a_d   = a_i;
      b_d   = b_i;
      idx_d = '0;
    end else if (state_q == BUSY) begin
      result_d[idx_q] = alu_result;
      idx_d           = idx_q + 1'b1;
    end
  end

  assign vector_o = result_q;

endmodule

// File: tb/tb_rowwise_operation_unit.sv
// Directed bench: one DUT instance per operation, all driven in lockstep from shared inputs.
module tb_rowwise_operation_unit;
  import config_pkg::*;

  localparam int IAdd = 0, ISub = 1, IMul = 2, IDiv = 3, IExp = 4;

  typedef struct {
    int          inst;
    int          lane;
    logic [15:0] exp_val;
  } lane_chk_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  vector_t    a_in = '0;
  vector_t    b_in = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [4:0] in_ready;
  logic [4:0] out_valid;
  vector_t    vec [5];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  rowwise_operation_unit #(.operation(ADD)) dut_add (
    .clk_i(clk), .rst_i(rst), .a_i(a_in), .b_i(b_in), .in_valid_i(in_valid),
    .in_ready_o(in_ready[IAdd]), .out_valid_o(out_valid[IAdd]), .out_ready_i(out_ready),
    .vector_o(vec[IAdd]));
  rowwise_operation_unit #(.operation(SUB)) dut_sub (
    .clk_i(clk), .rst_i(rst), .a_i(a_in), .b_i(b_in), .in_valid_i(in_valid),
    .in_ready_o(in_ready[ISub]), .out_valid_o(out_valid[ISub]), .out_ready_i(out_ready),
    .vector_o(vec[ISub]));
  rowwise_operation_unit #(.operation(MUL)) dut_mul (
    .clk_i(clk), .rst_i(rst), .a_i(a_in), .b_i(b_in), .in_valid_i(in_valid),
    .in_ready_o(in_ready[IMul]), .out_valid_o(out_valid[IMul]), .out_ready_i(out_ready),
    .vector_o(vec[IMul]));
  rowwise_operation_unit #(.operation(DIV)) dut_div (
    .clk_i(clk), .rst_i(rst), .a_i(a_in), .b_i(b_in), .in_valid_i(in_valid),
    .in_ready_o(in_ready[IDiv]), .out_valid_o(out_valid[IDiv]), .out_ready_i(out_ready),
    .vector_o(vec[IDiv]));
  rowwise_operation_unit #(.operation(EXP)) dut_exp (
    .clk_i(clk), .rst_i(rst), .a_i(a_in), .b_i(b_in), .in_valid_i(in_valid),
    .in_ready_o(in_ready[IExp]), .out_valid_o(out_valid[IExp]), .out_ready_i(out_ready),
    .vector_o(vec[IExp]));

  // Drive one request for a single cycle; it is accepted on the posedge in between.
  task automatic start_op(input vector_t a, input vector_t b);
    @(negedge clk);
    a_in = a; b_in = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Returns the negedge count after the accept edge at which out_valid is first seen.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (out_valid !== 5'h1F && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (out_valid !== 5'h1F) begin
      tests_run++; tests_failed++;
      $display("FAIL wait_valid: out_valid=%b after %0d cycles, required 11111", out_valid, lat);
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_lanes(input string name, input lane_chk_t chk [$]);
    foreach (chk[i]) begin
      tests_run++;
      if (vec[chk[i].inst][chk[i].lane] !== chk[i].exp_val) begin
        tests_failed++;
        $display("FAIL %s inst%0d lane%0d: got %h, required %h", name, chk[i].inst,
                 chk[i].lane, vec[chk[i].inst][chk[i].lane], chk[i].exp_val);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if (in_ready !== 5'b0 || out_valid !== 5'b0 || vec[IAdd] !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b vec=%h, required 0/0/0",
               in_ready, out_valid, vec[IAdd]);
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 5'h1F) begin
      tests_failed++;
      $display("FAIL reset_release: in_ready=%b, required 11111", in_ready);
    end
  endtask

  task automatic test_add();
    vector_t a, b, exp_add, exp_sub;
    int lat;
    for (int i = 0; i < VectorLength; i++) begin
      a[i] = 16'h0100; b[i] = 16'h0280; exp_add[i] = 16'h0380; exp_sub[i] = 16'hFE80;
    end
    start_op(a, b);
    wait_valid(lat);
    tests_run++;
    if (lat !== 9) begin
      tests_failed++;
      $display("FAIL add_latency: got %0d, required 9", lat);
    end
    tests_run++;
    if (vec[IAdd] !== exp_add || vec[ISub] !== exp_sub) begin
      tests_failed++;
      $display("FAIL add_vector: add=%h sub=%h, required %h / %h",
               vec[IAdd], vec[ISub], exp_add, exp_sub);
    end
    handoff();
  endtask

  task automatic test_saturation();
    vector_t a = '0, b = '0;
    int lat;
    a[0] = 16'h7F00; b[0] = 16'h0200;
    a[1] = 16'h8000; b[1] = 16'h0100;
    start_op(a, b);
    wait_valid(lat);
    check_lanes("saturation", '{
      '{IAdd, 0, 16'h7FFF}, '{ISub, 1, 16'h8000},
      '{ISub, 0, 16'h7D00}, '{IAdd, 1, 16'h8100}});
    handoff();
  endtask

  task automatic test_mul_div();
    vector_t a = '0, b = '0;
    int lat;
    a[0] = 16'h0180; b[0] = 16'hFE00;
    a[1] = 16'h0300; b[1] = 16'h0200;
    a[2] = 16'hFF00; b[2] = 16'h0000;
    a[3] = 16'h0100; b[3] = 16'h0000;
    a[4] = 16'h0100; b[4] = 16'h0300;
    a[5] = 16'hFF00; b[5] = 16'h0300;
    start_op(a, b);
    wait_valid(lat);
    check_lanes("mul_div", '{
      '{IMul, 0, 16'hFD00}, '{IMul, 1, 16'h0600}, '{IMul, 2, 16'h0000},
      '{IDiv, 1, 16'h0180}, '{IDiv, 0, 16'hFF40}, '{IDiv, 2, 16'h8000},
      '{IDiv, 3, 16'h7FFF}, '{IDiv, 4, 16'h0055}, '{IDiv, 5, 16'hFFAB}});
    handoff();
  endtask

  task automatic test_exp();
    vector_t a = '0, b;
    int lat;
    for (int i = 0; i < VectorLength; i++) b[i] = 16'h1234;
    a[1] = 16'h0100;
    a[2] = 16'h0600;
    a[3] = 16'hFF00;
    a[4] = 16'hF000;
    start_op(a, b);
    wait_valid(lat);
    check_lanes("exp", '{
      '{IExp, 0, 16'h0100}, '{IExp, 1, 16'h02E2}, '{IExp, 2, 16'h7FFF},
      '{IExp, 3, 16'h0063}, '{IExp, 4, 16'h0000}, '{IExp, 7, 16'h0100}});
    handoff();
  endtask

  task automatic test_backpressure();
    vector_t a, b, exp_add;
    int lat;
    int bad = 0;
    for (int i = 0; i < VectorLength; i++) begin
      a[i] = 16'(16'h0010 * i); b[i] = 16'h0001; exp_add[i] = 16'(16'h0010 * i + 1);
    end
    start_op(a, b);
    wait_valid(lat);
    for (int c = 0; c < 20; c++) begin
      in_valid = (c == 5);
      a_in = '1;
      @(negedge clk);
      if (out_valid !== 5'h1F || vec[IAdd] !== exp_add || in_ready !== 5'b0) bad++;
    end
    in_valid = 1'b0;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL backpressure_stable: %0d unstable cycles, required 0 (vec=%h)", bad, vec[IAdd]);
    end
    handoff();
    tests_run++;
    if (out_valid !== 5'b0 || in_ready !== 5'h1F) begin
      tests_failed++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b, required 00000/11111",
               out_valid, in_ready);
    end
    repeat (12) @(negedge clk);
    tests_run++;
    if (out_valid !== 5'b0 || vec[IAdd] !== exp_add) begin
      tests_failed++;
      $display("FAIL dropped_request: out_valid=%b vec=%h, required 00000 / %h",
               out_valid, vec[IAdd], exp_add);
    end
  endtask

  task automatic test_reset_mid_busy();
    vector_t a, b, exp_add;
    int lat;
    for (int i = 0; i < VectorLength; i++) begin
      a[i] = 16'h0200; b[i] = 16'h0100;
    end
    start_op(a, b);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 5'b0 || vec[IAdd] !== '0 || in_ready !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_busy: out_valid=%b vec=%h in_ready=%b, required 0/0/0",
               out_valid, vec[IAdd], in_ready);
    end
    rst = 1'b0;
    repeat (12) @(negedge clk);
    tests_run++;
    if (out_valid !== 5'b0 || in_ready !== 5'h1F) begin
      tests_failed++;
      $display("FAIL reset_discard: out_valid=%b in_ready=%b, required 00000/11111",
               out_valid, in_ready);
    end
    for (int i = 0; i < VectorLength; i++) begin
      a[i] = 16'h0040; b[i] = 16'h0010; exp_add[i] = 16'h0050;
    end
    start_op(a, b);
    wait_valid(lat);
    tests_run++;
    if (lat !== 9 || vec[IAdd] !== exp_add) begin
      tests_failed++;
      $display("FAIL post_reset_op: lat=%0d vec=%h, required 9 / %h", lat, vec[IAdd], exp_add);
    end
    handoff();
  endtask

  initial begin
    test_reset();
    test_add();
    test_saturation();
    test_mul_div();
    test_exp();
    test_backpressure();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
